// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes used by
// the decoder and this unit, plus the FSM state encoding.
package mult_div_unit_pkg;

   localparam int MD_WIDTH = 32;

   typedef enum logic [1:0] {
      MD_MULT  = 2'b00,
      MD_MULTU = 2'b01,
      MD_DIV   = 2'b10,
      MD_DIVU  = 2'b11
   } md_op_e;

   typedef enum logic [1:0] {
      MD_IDLE = 2'b00,
      MD_RUN  = 2'b01,
      MD_FIX  = 2'b10
   } md_state_e;

   function automatic logic md_is_div(input md_op_e op);
      return (op == MD_DIV) || (op == MD_DIVU);
   endfunction

   function automatic logic md_is_signed(input md_op_e op);
      return (op == MD_MULT) || (op == MD_DIV);
   endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit writing the architectural HI/LO pair.
// Works on magnitudes for WIDTH steps, then applies sign correction in FIX.
module mult_div_unit
   import mult_div_unit_pkg::*;
#(
   parameter int WIDTH = MD_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] rs_data,
   input  logic [WIDTH-1:0] rt_data,
   input  logic             mthi,
   input  logic             mtlo,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done
);

   // Handshake: start/mthi/mtlo are sampled on a rising edge only while
   // busy=0 (start has priority over a move in the same cycle). busy stays
   // high until the edge that writes hi/lo and raises done for one cycle.

   localparam int CW = $clog2(WIDTH);
   localparam int AW = 2 * WIDTH + 1;

   md_state_e        state_q, state_d;
   logic [CW-1:0]    count_q, count_d;
   md_op_e           op_q, op_d;
   logic             sign_diff_q, sign_diff_d;
   logic             rs_neg_q, rs_neg_d;
   logic             div_zero_q, div_zero_d;
   logic [WIDTH-1:0] rs_raw_q, rs_raw_d;
   logic [WIDTH-1:0] b_mag_q, b_mag_d;
   logic [AW-1:0]    acc_q, acc_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             done_q, done_d;

   md_op_e           op_in;
   logic             in_rs_neg;
   logic             in_rt_neg;
   logic [WIDTH-1:0] in_rs_mag;
   logic [WIDTH-1:0] in_rt_mag;

   logic             step_div;
   logic [WIDTH:0]   rem_shift;
   logic [WIDTH:0]   add_x;
   logic [WIDTH:0]   add_y;
   logic [WIDTH+1:0] add_sum;
   logic             borrow;
   logic [AW-1:0]    acc_step;

   logic [2*WIDTH-1:0] prod_fixed;
   logic [WIDTH-1:0]   quot_fixed;
   logic [WIDTH-1:0]   rem_fixed;

   // Operand capture: signed ops work on magnitudes; the most negative value
   // simply becomes the unsigned 2^(WIDTH-1).
   always_comb begin
      op_in     = md_op_e'(op);
      in_rs_neg = md_is_signed(op_in) && rs_data[WIDTH-1];
      in_rt_neg = md_is_signed(op_in) && rt_data[WIDTH-1];
      in_rs_mag = in_rs_neg ? -rs_data : rs_data;
      in_rt_mag = in_rt_neg ? -rt_data : rt_data;
   end

   // One shared adder: add for multiply, subtract with borrow-out for divide.
   always_comb begin
      step_div  = md_is_div(op_q);
      rem_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      add_x     = step_div ? rem_shift : acc_q[2*WIDTH:WIDTH];
      add_y     = (step_div || acc_q[0]) ? {1'b0, b_mag_q} : '0;
      add_sum   = {1'b0, add_x} + ({1'b0, add_y} ^ {(WIDTH+2){step_div}})
                + {{(WIDTH+1){1'b0}}, step_div};
      borrow    = add_sum[WIDTH+1];
      if (step_div) begin
         acc_step = {1'b0,
                     (borrow ? rem_shift[WIDTH-1:0] : add_sum[WIDTH-1:0]),
                     acc_q[WIDTH-2:0], ~borrow};
      end else begin
         acc_step = {1'b0, add_sum[WIDTH:0], acc_q[WIDTH-1:1]};
      end
   end

   always_comb begin
      prod_fixed = sign_diff_q ? -acc_q[2*WIDTH-1:0] : acc_q[2*WIDTH-1:0];
      quot_fixed = sign_diff_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      rem_fixed  = rs_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
   end

   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      op_d        = op_q;
      sign_diff_d = sign_diff_q;
      rs_neg_d    = rs_neg_q;
      div_zero_d  = div_zero_q;
      rs_raw_d    = rs_raw_q;
      b_mag_d     = b_mag_q;
      acc_d       = acc_q;
      hi_d        = hi_q;
      lo_d        = lo_q;
      done_d      = 1'b0;

      case (state_q)
         MD_IDLE: begin
            if (start) begin
               state_d     = MD_RUN;
               count_d     = '0;
               op_d        = op_in;
               sign_diff_d = in_rs_neg ^ in_rt_neg;
               rs_neg_d    = in_rs_neg;
               div_zero_d  = (rt_data == '0);
               rs_raw_d    = rs_data;
               b_mag_d     = in_rt_mag;
               acc_d       = {{(WIDTH+1){1'b0}}, in_rs_mag};
            end else begin
               if (mthi) hi_d = rs_data;
               if (mtlo) lo_d = rs_data;
            end
         end

         MD_RUN: begin
            acc_d   = acc_step;
            count_d = count_q + 1'b1;
            if (count_q == CW'(WIDTH - 1)) state_d = MD_FIX;
         end

         MD_FIX: begin
            state_d = MD_IDLE;
            done_d  = 1'b1;
            if (!md_is_div(op_q)) begin
               hi_d = prod_fixed[2*WIDTH-1:WIDTH];
               lo_d = prod_fixed[WIDTH-1:0];
            end else if (div_zero_q) begin
               hi_d = rs_raw_q;
               lo_d = '1;
            end else begin
               hi_d = rem_fixed;
               lo_d = quot_fixed;
            end
         end

         default: state_d = MD_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= MD_IDLE;
         count_q     <= '0;
         op_q        <= MD_MULT;
         sign_diff_q <= 1'b0;
         rs_neg_q    <= 1'b0;
         div_zero_q  <= 1'b0;
         rs_raw_q    <= '0;
         b_mag_q     <= '0;
         acc_q       <= '0;
         hi_q        <= '0;
         lo_q        <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         op_q        <= op_d;
         sign_diff_q <= sign_diff_d;
         rs_neg_q    <= rs_neg_d;
         div_zero_q  <= div_zero_d;
         rs_raw_q    <= rs_raw_d;
         b_mag_q     <= b_mag_d;
         acc_q       <= acc_d;
         hi_q        <= hi_d;
         lo_q        <= lo_d;
         done_q      <= done_d;
      end
   end

   assign hi   = hi_q;
   assign lo   = lo_q;
   assign busy = (state_q != MD_IDLE);
   assign done = done_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: expected HI/LO pairs are queued when an
// op is launched and compared when done pulses.
module tb_mult_div_unit;
   import mult_div_unit_pkg::*;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [1:0]   op;
   logic [W-1:0] rs_data;
   logic [W-1:0] rt_data;
   logic         mthi;
   logic         mtlo;
   logic [W-1:0] hi;
   logic [W-1:0] lo;
   logic         busy;
   logic         done;

   int n_checks = 0;
   int n_errors = 0;
   int unsigned cyc = 0;
   int unsigned busy_cnt = 0;
   int unsigned start_cyc = 0;
   int unsigned busy_base = 0;
   logic [W-1:0] exp_q[$];

   mult_div_unit #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op),
      .rs_data(rs_data), .rt_data(rt_data), .mthi(mthi), .mtlo(mtlo),
      .hi(hi), .lo(lo), .busy(busy), .done(done)
   );

   // clock / cycle bookkeeping
   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (busy === 1'b1) busy_cnt <= busy_cnt + 1;
   end

   task automatic check(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   task automatic push_exp(input logic [W-1:0] eh, input logic [W-1:0] el);
      exp_q.push_back(eh);
      exp_q.push_back(el);
   endtask

   // reference model built on native 64-bit arithmetic
   task automatic push_model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      longint sa, sb, p, q, r;
      logic [63:0] up;
      logic [W-1:0] eh, el;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      eh = '0;
      el = '0;
      case (o)
         MD_MULT: begin
            p  = sa * sb;
            eh = p[63:32];
            el = p[31:0];
         end
         MD_MULTU: begin
            up = {32'd0, a} * {32'd0, b};
            eh = up[63:32];
            el = up[31:0];
         end
         MD_DIV: begin
            if (b == '0) begin
               eh = a;
               el = '1;
            end else begin
               q  = sa / sb;
               r  = sa % sb;
               eh = r[31:0];
               el = q[31:0];
            end
         end
         default: begin
            if (b == '0) begin
               eh = a;
               el = '1;
            end else begin
               eh = a % b;
               el = a / b;
            end
         end
      endcase
      push_exp(eh, el);
   endtask

   // driver: present start for one cycle; returns at the negedge after the sampling edge
   task automatic drive_start(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clk);
      start     = 1'b1;
      op        = o;
      rs_data   = a;
      rt_data   = b;
      start_cyc = cyc;
      busy_base = busy_cnt;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      logic [W-1:0] eh, el;
      bit got;
      got = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (done === 1'b1) begin
            got = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!got) begin
         check({tag, " done_timeout"}, {31'd0, done}, 1);
         if (exp_q.size() >= 2) begin
            eh = exp_q.pop_front();
            el = exp_q.pop_front();
         end
         return;
      end
      eh = exp_q.pop_front();
      el = exp_q.pop_front();
      check({tag, " hi"}, hi, eh);
      check({tag, " lo"}, lo, el);
      check({tag, " latency"}, W'(cyc - start_cyc), 34);
      check({tag, " busy_cycles"}, W'(busy_cnt - busy_base), 33);
      check({tag, " busy_at_done"}, {31'd0, busy}, 0);
      @(negedge clk);
      check({tag, " done_width"}, {31'd0, done}, 0);
   endtask

   logic [W-1:0] corner [0:5];

   initial begin
      int seen;
      logic [1:0] ro;
      logic [W-1:0] ra, rb;

      corner[0] = 32'h0000_0000;
      corner[1] = 32'h8000_0000;
      corner[2] = 32'hFFFF_FFFF;
      corner[3] = 32'h7FFF_FFFF;
      corner[4] = 32'h0000_0001;
      corner[5] = 32'hFFFF_FFFE;

      reset   = 1'b1;
      start   = 1'b0;
      op      = 2'b00;
      rs_data = '0;
      rt_data = '0;
      mthi    = 1'b0;
      mtlo    = 1'b0;
      repeat (3) @(negedge clk);
      check("reset hi", hi, 0);
      check("reset lo", lo, 0);
      check("reset busy", {31'd0, busy}, 0);
      check("reset done", {31'd0, done}, 0);
      reset = 1'b0;

      // directed vectors
      push_exp(32'hFFFF_FFFF, 32'hFFFF_FFEB);
      drive_start(MD_MULT, 32'd7, 32'hFFFF_FFFD);
      wait_done("mult_7x-3");

      push_exp(32'hFFFF_FFFE, 32'h0000_0001);
      drive_start(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done("multu_max");

      push_exp(32'hFFFF_FFFF, 32'hFFFF_FFFD);
      drive_start(MD_DIV, 32'hFFFF_FFF9, 32'd2);
      wait_done("div_-7/2");

      push_exp(32'h0000_0000, 32'h8000_0000);
      drive_start(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done("div_overflow");

      push_exp(32'd100, 32'hFFFF_FFFF);
      drive_start(MD_DIVU, 32'd100, 32'd0);
      wait_done("divu_by_zero");

      push_exp(32'hFFFF_FFFB, 32'hFFFF_FFFF);
      drive_start(MD_DIV, 32'hFFFF_FFFB, 32'd0);
      wait_done("div_by_zero");

      // start and mthi while busy are both ignored
      push_exp(32'd0, 32'd12);
      drive_start(MD_MULT, 32'd3, 32'd4);
      repeat (3) @(negedge clk);
      start   = 1'b1;
      op      = MD_DIVU;
      mthi    = 1'b1;
      rs_data = 32'h55;
      @(negedge clk);
      start = 1'b0;
      mthi  = 1'b0;
      check("busy_stale_hi", hi, 32'hFFFF_FFFB);
      wait_done("mult_ignore_busy");

      // moves in idle: no done pulse
      mtlo    = 1'b1;
      rs_data = 32'hAB;
      @(negedge clk);
      mtlo = 1'b0;
      check("mtlo lo", lo, 32'hAB);
      check("mtlo hi", hi, 32'd0);
      check("mtlo done", {31'd0, done}, 0);

      mthi    = 1'b1;
      mtlo    = 1'b1;
      rs_data = 32'h1234;
      @(negedge clk);
      mthi = 1'b0;
      mtlo = 1'b0;
      check("mthilo hi", hi, 32'h1234);
      check("mthilo lo", lo, 32'h1234);

      // start beats mthi in the same idle cycle
      @(negedge clk);
      start     = 1'b1;
      mthi      = 1'b1;
      op        = MD_MULTU;
      rs_data   = 32'd2;
      rt_data   = 32'd3;
      start_cyc = cyc;
      busy_base = busy_cnt;
      push_exp(32'd0, 32'd6);
      @(negedge clk);
      start = 1'b0;
      mthi  = 1'b0;
      check("start_wins hi", hi, 32'h1234);
      wait_done("start_wins");

      // randomized ops with corner operands mixed in
      for (int n = 0; n < 12; n++) begin
         ro = 2'($urandom_range(0, 3));
         ra = ($urandom_range(0, 2) == 0) ? corner[$urandom_range(0, 5)] : W'($urandom);
         rb = ($urandom_range(0, 2) == 0) ? corner[$urandom_range(0, 5)] : W'($urandom);
         if ($urandom_range(0, 3) == 0) rb = W'($urandom_range(1, 255));
         push_model(ro, ra, rb);
         drive_start(ro, ra, rb);
         wait_done($sformatf("rand%0d_op%0d", n, ro));
      end

      // reset in the middle of a DIV aborts it
      mthi    = 1'b1;
      mtlo    = 1'b1;
      rs_data = 32'h77;
      @(negedge clk);
      mthi = 1'b0;
      mtlo = 1'b0;
      drive_start(MD_DIV, 32'hFFFF_FF9C, 32'd7);
      repeat (9) @(negedge clk);
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      check("abort busy", {31'd0, busy}, 0);
      check("abort hi", hi, 0);
      check("abort lo", lo, 0);
      check("abort done", {31'd0, done}, 0);
      @(negedge clk);
      reset = 1'b0;
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (done === 1'b1) seen++;
      end
      check("abort no_done", W'(seen), 0);

      push_exp(32'd0, 32'd10);
      drive_start(MD_MULTU, 32'd2, 32'd5);
      wait_done("after_reset");

      check("queue_empty", W'(exp_q.size()), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
